// File: rtl/image_loader.sv
// ============================================================================
// Module   : image_loader
// Purpose  : Packs a valid/ready byte stream into 16-bit words and writes them
//            sequentially into the 1-bpp VGA frame RAM, one frame per start.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module image_loader #(
  parameter int WORDS      = 7500,
  parameter int ADDR_WIDTH = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_frame_start,
  input  logic [7:0]            i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [ADDR_WIDTH-1:0] o_w_address,
  output logic [15:0]           o_w_data,
  output logic                  o_w_enable,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOW   = 2'd1;
  localparam logic [1:0] S_HIGH  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(WORDS - 1);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [7:0]            r_low;
  logic [ADDR_WIDTH-1:0] r_w_address;
  logic [15:0]           r_w_data;
  logic                  r_w_enable;
  logic                  r_frame_done;
  logic                  r_overrun;
  logic                  w_accept;

  assign o_ready     = (r_state != S_WRITE);
  assign o_busy      = (r_state != S_IDLE);
  // A start pulse takes priority, so the byte on the bus that cycle is left pending.
  assign w_accept    = i_valid && o_ready && !i_frame_start;

  assign o_w_address = r_w_address;
  assign o_w_data    = r_w_data;
  assign o_w_enable  = r_w_enable;
  assign o_overrun   = r_overrun;
  // A restart during the final write cancels the completion report for that frame.
  assign o_frame_done = r_frame_done && !i_frame_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_low        <= '0;
      r_w_address  <= '0;
      r_w_data     <= '0;
      r_w_enable   <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_w_enable   <= 1'b0;
      r_frame_done <= 1'b0;
      if (i_frame_start) begin
        r_state <= S_LOW;
        r_count <= '0;
        r_low   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) r_overrun <= 1'b1;
          end
          S_LOW: begin
            if (w_accept) begin
              r_low   <= i_data;
              r_state <= S_HIGH;
            end
          end
          S_HIGH: begin
            if (w_accept) begin
              r_w_data     <= {i_data, r_low};
              r_w_address  <= r_count;
              r_w_enable   <= 1'b1;
              r_frame_done <= (r_count == C_LAST);
              r_state      <= S_WRITE;
            end
          end
          default: begin
            if (r_count == C_LAST) begin
              r_count <= '0;
              r_state <= S_IDLE;
            end else begin
              r_count <= r_count + 1'b1;
              r_state <= S_LOW;
            end
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_image_loader.sv
// ============================================================================
// Module   : tb_image_loader
// Purpose  : Self-checking bench for image_loader (WORDS=4 and WORDS=7500).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_image_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_frame_start = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = 8'h00;

  logic        s_ready, s_en, s_busy, s_done, s_ovr;
  logic [1:0]  s_addr;
  logic [15:0] s_data;
  logic        b_ready, b_en, b_busy, b_done, b_ovr;
  logic [12:0] b_addr;
  logic [15:0] b_data;

  image_loader #(.WORDS(4)) u_small (
    .clk(clk), .rst_n(rst_n), .i_frame_start(i_frame_start), .i_data(i_data),
    .i_valid(i_valid), .o_ready(s_ready), .o_w_address(s_addr), .o_w_data(s_data),
    .o_w_enable(s_en), .o_busy(s_busy), .o_frame_done(s_done), .o_overrun(s_ovr)
  );

  image_loader #(.WORDS(7500)) u_big (
    .clk(clk), .rst_n(rst_n), .i_frame_start(i_frame_start), .i_data(i_data),
    .i_valid(i_valid), .o_ready(b_ready), .o_w_address(b_addr), .o_w_data(b_data),
    .o_w_enable(b_en), .o_busy(b_busy), .o_frame_done(b_done), .o_overrun(b_ovr)
  );

  always #5 clk = ~clk;

  bit          big = 1'b0;
  logic        t_ready, t_en, t_busy, t_done, t_ovr;
  logic [15:0] t_addr, t_data;
  assign t_ready = big ? b_ready : s_ready;
  assign t_en    = big ? b_en    : s_en;
  assign t_busy  = big ? b_busy  : s_busy;
  assign t_done  = big ? b_done  : s_done;
  assign t_ovr   = big ? b_ovr   : s_ovr;
  assign t_addr  = big ? 16'(b_addr) : 16'(s_addr);
  assign t_data  = big ? b_data  : s_data;

  int total = 0;
  int bad   = 0;

  // Reference model: frame position, pending low byte, one stall cycle after each word.
  int          m_words = 4;
  bit          m_in, m_have, m_stall, m_fin, m_ovr;
  logic [7:0]  m_low;
  int          m_word;
  logic        e_en, e_done;
  logic [15:0] h_addr, h_data;

  logic [15:0] sb  [7500];
  logic [15:0] ram [7500];
  int          n_writes, n_dones;

  logic [15:0] wl_addr[$];
  logic [15:0] wl_data[$];
  logic        wl_done[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_in = 0; m_have = 0; m_stall = 0; m_fin = 0; m_ovr = 0;
    m_low = 0; m_word = 0; e_en = 0; e_done = 0; h_addr = 0; h_data = 0;
  endfunction

  function automatic void model_step(input logic s, input logic v, input logic [7:0] d);
    e_en = 0; e_done = 0;
    if (s) begin
      m_in = 1; m_have = 0; m_word = 0; m_stall = 0; m_fin = 0;
    end else if (m_stall) begin
      m_stall = 0;
      if (m_fin) begin m_in = 0; m_fin = 0; end
    end else if (v) begin
      if (!m_in) m_ovr = 1;
      else if (!m_have) begin m_low = d; m_have = 1; end
      else begin
        e_en = 1; h_addr = 16'(m_word); h_data = {d, m_low};
        if (big) sb[m_word] = h_data;
        m_have = 0; m_stall = 1;
        m_fin = (m_word == m_words - 1);
        e_done = m_fin;
        m_word = m_fin ? 0 : m_word + 1;
      end
    end
  endfunction

  task automatic check_outputs();
    chk("ready", t_ready, !m_stall);
    chk("busy", t_busy, m_in);
    chk("overrun", t_ovr, m_ovr);
    chk("w_enable", t_en, e_en);
    chk("frame_done", t_done, e_done);
    chk("w_address", t_addr, h_addr);
    chk("w_data", t_data, h_data);
    if (t_en === 1'b1) begin
      wl_addr.push_back(t_addr); wl_data.push_back(t_data); wl_done.push_back(t_done);
      n_writes++;
      if (big && t_addr < 16'd7500) ram[t_addr] = t_data;
    end
    if (t_done === 1'b1) n_dones++;
  endtask

  task automatic tick(input logic s, input logic v, input logic [7:0] d);
    i_frame_start = s; i_valid = v; i_data = d;
    @(posedge clk); #1;
    model_step(s, v, d);
    check_outputs();
  endtask

  // Holds the byte on the bus until it is taken.
  task automatic send(input logic [7:0] d);
    for (int k = 0; k < 4; k++) begin
      bit rdy = !m_stall;
      tick(1'b0, 1'b1, d);
      if (rdy) break;
    end
  endtask

  task automatic clear_log();
    wl_addr.delete(); wl_data.delete(); wl_done.delete();
  endtask

  task automatic expw(input int idx, input logic [15:0] a, input logic [15:0] d, input logic dn);
    if (idx < wl_addr.size()) begin
      chk($sformatf("wr%0d_addr", idx), wl_addr[idx], a);
      chk($sformatf("wr%0d_data", idx), wl_data[idx], d);
      chk($sformatf("wr%0d_done", idx), wl_done[idx], dn);
    end else chk($sformatf("wr%0d_missing", idx), 32'(wl_addr.size()), 32'(idx + 1));
  endtask

  task automatic do_reset();
    i_frame_start = 0; i_valid = 0; i_data = 0;
    rst_n = 0; #1;
    m_reset();
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
  endtask

  initial begin
    // Reset and first complete frame on the 4-word instance
    m_reset();
    do_reset();
    tick(1, 0, 0);
    clear_log();
    for (int b = 1; b <= 8; b++) send(8'(b));
    repeat (3) tick(0, 0, 0);
    chk("frame1_count", wl_addr.size(), 4);
    expw(0, 0, 16'h0201, 0); expw(1, 1, 16'h0403, 0);
    expw(2, 2, 16'h0605, 0); expw(3, 3, 16'h0807, 1);
    chk("frame1_idle_busy", t_busy, 0);

    // Byte outside a frame, then a normal frame with overrun still set
    clear_log();
    tick(0, 1, 8'hAA);
    tick(0, 0, 0);
    chk("overrun_set", t_ovr, 1);
    chk("overrun_nowrite", wl_addr.size(), 0);
    tick(1, 0, 0);
    for (int b = 8'h21; b <= 8'h28; b++) send(8'(b));
    repeat (2) tick(0, 0, 0);
    chk("frame2_count", wl_addr.size(), 4);
    expw(0, 0, 16'h2221, 0); expw(3, 3, 16'h2827, 1);
    chk("overrun_sticky", t_ovr, 1);

    // Mid-frame restart discards the partial low byte
    clear_log();
    tick(1, 0, 0);
    send(8'h11); send(8'h22); send(8'h33);
    tick(1, 0, 0);
    send(8'h44); send(8'h55);
    repeat (2) tick(0, 0, 0);
    chk("restart_count", wl_addr.size(), 2);
    expw(0, 0, 16'h2211, 0); expw(1, 0, 16'h5544, 0);

    // Start coincident with a valid byte in the high-byte phase
    clear_log();
    tick(1, 0, 0);
    send(8'h10);
    tick(1, 1, 8'h77);
    send(8'h77); send(8'h88);
    repeat (2) tick(0, 0, 0);
    chk("coinc_count", wl_addr.size(), 1);
    expw(0, 0, 16'h8877, 0);

    // Asynchronous reset between the two bytes of word 2
    clear_log();
    tick(1, 0, 0);
    for (int b = 1; b <= 5; b++) send(8'(8'h30 + b));
    #2 rst_n = 0; #1;
    m_reset();
    check_outputs();
    chk("rst_word_count", wl_addr.size(), 2);
    @(negedge clk); rst_n = 1;
    tick(0, 1, 8'h5A);
    tick(0, 0, 0);
    chk("post_rst_overrun", t_ovr, 1);
    chk("post_rst_nowrite", wl_addr.size(), 2);

    // Full 7500-word frame with random bytes and valid gaps
    big = 1; m_words = 7500;
    do_reset();
    n_writes = 0; n_dones = 0;
    clear_log();
    tick(1, 0, 0);
    for (int c = 0; c < 60000 && n_writes < 7500; c++)
      tick(0, $urandom_range(0, 3) != 0, 8'($urandom));
    repeat (3) tick(0, 0, 0);
    chk("big_writes", n_writes, 7500);
    chk("big_dones", n_dones, 1);
    chk("big_idle", t_busy, 0);
    begin
      int mism = 0;
      for (int a = 0; a < 7500; a++) if (ram[a] !== sb[a]) mism++;
      chk("big_ram_mismatches", mism, 0);
    end
    clear_log();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
